// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding-select encodings,
// the "operand unused" Tuse marker and the shadow pipeline entry.
package hazard_unit_pkg;

    // D-stage forwarding selects
    localparam logic [1:0] FWD_D_RF   = 2'b00;
    localparam logic [1:0] FWD_D_E    = 2'b01;
    localparam logic [1:0] FWD_D_M    = 2'b10;
    localparam logic [1:0] FWD_D_W    = 2'b11;

    // E-stage forwarding selects
    localparam logic [1:0] FWD_E_PIPE = 2'b00;
    localparam logic [1:0] FWD_E_M    = 2'b01;
    localparam logic [1:0] FWD_E_W    = 2'b10;

    // M-stage forwarding selects
    localparam logic       FWD_M_PIPE = 1'b0;
    localparam logic       FWD_M_W    = 1'b1;

    // Tuse value meaning the operand is never read
    localparam logic [3:0] TUSE_NONE  = 4'd5;

    // One instruction's worth of hazard bookkeeping in the shadow pipeline
    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic       wen;
        logic [3:0] tnew;
        logic       md;
        logic       div;
    } shadow_entry_t;

    // Count down towards zero without wrapping
    function automatic logic [3:0] sat_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    // Move an entry one stage down the pipe
    function automatic shadow_entry_t age(input shadow_entry_t e);
        shadow_entry_t r;
        r      = e;
        r.tnew = sat_dec(e.tnew);
        return r;
    endfunction

    // True when entry e will write register a (never $0)
    function automatic logic match(input shadow_entry_t e, input logic [4:0] a);
        return e.wen && (e.a3 == a) && (a != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_unit_md_busy_cnt.sv
// Multiply/divide occupancy counter: loaded when a mult/div leaves E,
// counts down to zero, and a new load always restarts the count.
module md_busy_cnt
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] load_val;

    assign load_val = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    assign busy     = (count != '0);

    // Load on a starting instruction, otherwise drain towards zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for a 5-stage MIPS pipeline.
// A shadow copy of E/M/W tracks destinations and Tnew so stalls and
// forwarding selects can be derived from D-stage Tuse information.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_a1,
    input  logic [4:0] d_a2,
    input  logic       d_a1use,
    input  logic       d_a2use,
    input  logic [3:0] d_rs_tuse,
    input  logic [3:0] d_rt_tuse,
    input  logic [4:0] d_a3,
    input  logic       d_reg_write,
    input  logic [3:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    shadow_entry_t e_q, m_q, w_q;
    shadow_entry_t d_entry;
    logic          rs_stall, rt_stall, md_stall;

    // D-stage instruction as it would look once it sits in E
    always_comb begin
        d_entry      = '0;
        d_entry.a1   = d_a1;
        d_entry.a2   = d_a2;
        d_entry.a3   = d_a3;
        d_entry.wen  = d_reg_write && (d_a3 != 5'd0);
        d_entry.tnew = sat_dec(d_tnew);
        d_entry.md   = d_md_start;
        d_entry.div  = d_md_div;
    end

    // Shadow pipeline: a stall bubbles E while M and W keep draining
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= stall ? shadow_entry_t'('0) : d_entry;
            m_q <= age(e_q);
            w_q <= age(m_q);
        end
    end

    // Data stalls: a producer in E or M will not be ready by the reader's Tuse
    always_comb begin
        rs_stall = d_a1use &&
                   ((match(e_q, d_a1) && (e_q.tnew > d_rs_tuse)) ||
                    (match(m_q, d_a1) && (m_q.tnew > d_rs_tuse)));
        rt_stall = d_a2use &&
                   ((match(e_q, d_a2) && (e_q.tnew > d_rt_tuse)) ||
                    (match(m_q, d_a2) && (m_q.tnew > d_rt_tuse)));
        md_stall = d_md_use && (md_busy || e_q.md);
        stall    = rs_stall || rt_stall || md_stall;
    end

    // Newest matching producer wins; one that is not ready yet hides older ones
    function automatic logic [1:0] fwd_d_sel(input shadow_entry_t e,
                                             input shadow_entry_t m,
                                             input shadow_entry_t w,
                                             input logic [4:0]    a);
        if (match(e, a))      return (e.tnew == 4'd0) ? FWD_D_E : FWD_D_RF;
        else if (match(m, a)) return (m.tnew == 4'd0) ? FWD_D_M : FWD_D_RF;
        else if (match(w, a)) return FWD_D_W;
        else                  return FWD_D_RF;
    endfunction

    // Forwarding selects for the D, E and M stage operand muxes
    always_comb begin
        fwd_d_rs = fwd_d_sel(e_q, m_q, w_q, d_a1);
        fwd_d_rt = fwd_d_sel(e_q, m_q, w_q, d_a2);

        if (match(m_q, e_q.a1) && (m_q.tnew == 4'd0)) fwd_e_rs = FWD_E_M;
        else if (match(w_q, e_q.a1))                  fwd_e_rs = FWD_E_W;
        else                                          fwd_e_rs = FWD_E_PIPE;

        if (match(m_q, e_q.a2) && (m_q.tnew == 4'd0)) fwd_e_rt = FWD_E_M;
        else if (match(w_q, e_q.a2))                  fwd_e_rt = FWD_E_W;
        else                                          fwd_e_rt = FWD_E_PIPE;

        fwd_m_rt = match(w_q, m_q.a2) ? FWD_M_W : FWD_M_PIPE;
    end

    // Fields the shadow pipe carries for completeness but nothing consumes
    logic shadow_unused;
    assign shadow_unused = ^{m_q.a1, m_q.md, m_q.div,
                             w_q.a1, w_q.a2, w_q.tnew, w_q.md, w_q.div};

    md_busy_cnt #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (e_q.md),
        .is_div (e_q.div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: each task drives one scenario and
// checks stall / forwarding / md_busy against hand-computed values.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_a1, d_a2, d_a3;
    logic       d_a1use, d_a2use, d_reg_write;
    logic [3:0] d_rs_tuse, d_rt_tuse, d_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall, fwd_m_rt, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_a1(d_a1), .d_a2(d_a2), .d_a1use(d_a1use), .d_a2use(d_a2use),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_a3(d_a3), .d_reg_write(d_reg_write), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
        .md_busy(md_busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [4:0] a1, input logic a1use, input logic [3:0] rs_tuse,
                           input logic [4:0] a2, input logic a2use, input logic [3:0] rt_tuse,
                           input logic [4:0] a3, input logic regw, input logic [3:0] tnew,
                           input logic mds, input logic mdd, input logic mdu);
        d_a1 = a1; d_a1use = a1use; d_rs_tuse = rs_tuse;
        d_a2 = a2; d_a2use = a2use; d_rt_tuse = rt_tuse;
        d_a3 = a3; d_reg_write = regw; d_tnew = tnew;
        d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
        #1;
    endtask

    task automatic drive_nop();
        drive_d(5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        drive_nop();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        // lw $1 and a div sit in D while reset is held: neither may be captured
        drive_d(5'd2, 1'b1, 4'd1, 5'd0, 1'b0, TUSE_NONE, 5'd1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
        step(); step();
        reset = 1'b0;
        drive_nop();
        n_checks++; if (stall !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
        n_checks++; if (fwd_d_rs !== 2'b00)  begin n_fail++; $display("[TB] FAIL reset_fwd_d_rs: got %0b want 00", fwd_d_rs); end
        n_checks++; if (fwd_d_rt !== 2'b00)  begin n_fail++; $display("[TB] FAIL reset_fwd_d_rt: got %0b want 00", fwd_d_rt); end
        n_checks++; if (fwd_e_rs !== 2'b00)  begin n_fail++; $display("[TB] FAIL reset_fwd_e_rs: got %0b want 00", fwd_e_rs); end
        n_checks++; if (fwd_e_rt !== 2'b00)  begin n_fail++; $display("[TB] FAIL reset_fwd_e_rt: got %0b want 00", fwd_e_rt); end
        n_checks++; if (fwd_m_rt !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_fwd_m_rt: got %0b want 0", fwd_m_rt); end
        n_checks++; if (md_busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_md_busy: got %0b want 0", md_busy); end
        // beq $1,$1 reading HI/LO-free; E must still be a bubble, so no stall
        drive_d(5'd1, 1'b1, 4'd0, 5'd1, 1'b1, 4'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (stall !== 1'b0)      begin n_fail++; $display("[TB] FAIL reset_priority_stall: got %0b want 0", stall); end
        flush();
    endtask

    task automatic test_load_use();
        // lw $1, 0($2)
        drive_d(5'd2, 1'b1, 4'd1, 5'd0, 1'b0, TUSE_NONE, 5'd1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL lu_first_stall: got %0b want 0", stall); end
        step();
        // add $2, $1, $3
        drive_d(5'd1, 1'b1, 4'd1, 5'd3, 1'b1, 4'd1, 5'd2, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b1)     begin n_fail++; $display("[TB] FAIL lu_stall: got %0b want 1", stall); end
        n_checks++; if (fwd_d_rs !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_no_fwd_from_e: got %0b want 00", fwd_d_rs); end
        step();
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL lu_release: got %0b want 0", stall); end
        step();
        drive_nop();
        n_checks++; if (fwd_e_rs !== 2'b10) begin n_fail++; $display("[TB] FAIL lu_fwd_e_rs: got %0b want 10", fwd_e_rs); end
        n_checks++; if (fwd_e_rt !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_fwd_e_rt: got %0b want 00", fwd_e_rt); end
        flush();
    endtask

    task automatic test_branch();
        // add $1, $2, $3 then beq $1, $1
        drive_d(5'd2, 1'b1, 4'd1, 5'd3, 1'b1, 4'd1, 5'd1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive_d(5'd1, 1'b1, 4'd0, 5'd1, 1'b1, 4'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b1)     begin n_fail++; $display("[TB] FAIL br_stall: got %0b want 1", stall); end
        step();
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL br_release: got %0b want 0", stall); end
        n_checks++; if (fwd_d_rs !== 2'b10) begin n_fail++; $display("[TB] FAIL br_fwd_d_rs: got %0b want 10", fwd_d_rs); end
        n_checks++; if (fwd_d_rt !== 2'b10) begin n_fail++; $display("[TB] FAIL br_fwd_d_rt: got %0b want 10", fwd_d_rt); end
        flush();
    endtask

    task automatic test_fwd_d_sources();
        // jal: $31 known in D, so it is ready as soon as it reaches E
        drive_d(5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, TUSE_NONE, 5'd31, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        step();
        // jr $31
        drive_d(5'd31, 1'b1, 4'd0, 5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL fe_stall: got %0b want 0", stall); end
        n_checks++; if (fwd_d_rs !== 2'b01) begin n_fail++; $display("[TB] FAIL fe_fwd_d_rs: got %0b want 01", fwd_d_rs); end
        flush();
        // add $5 then two bubbles: producer sits in W
        drive_d(5'd2, 1'b1, 4'd1, 5'd3, 1'b1, 4'd1, 5'd5, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive_nop();
        step(); step();
        drive_d(5'd5, 1'b1, 4'd0, 5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (fwd_d_rs !== 2'b11) begin n_fail++; $display("[TB] FAIL fw_fwd_d_rs: got %0b want 11", fwd_d_rs); end
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL fw_stall: got %0b want 0", stall); end
        flush();
    endtask

    task automatic test_back_to_back();
        // add $6 ; add $6 ; reader of $6 with Tuse 1
        drive_d(5'd2, 1'b1, 4'd1, 5'd3, 1'b1, 4'd1, 5'd6, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive_d(5'd7, 1'b1, 4'd1, 5'd8, 1'b1, 4'd1, 5'd6, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive_d(5'd6, 1'b1, 4'd1, 5'd0, 1'b0, TUSE_NONE, 5'd9, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL b2b_stall: got %0b want 0", stall); end
        n_checks++; if (fwd_d_rs !== 2'b00) begin n_fail++; $display("[TB] FAIL b2b_blocked_fwd: got %0b want 00", fwd_d_rs); end
        step();
        drive_nop();
        n_checks++; if (fwd_e_rs !== 2'b01) begin n_fail++; $display("[TB] FAIL b2b_fwd_e_rs: got %0b want 01", fwd_e_rs); end
        flush();
    endtask

    task automatic test_zero_reg();
        // lw $0 then beq $0,$0
        drive_d(5'd2, 1'b1, 4'd1, 5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive_d(5'd0, 1'b1, 4'd0, 5'd0, 1'b1, 4'd0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL z_stall: got %0b want 0", stall); end
        n_checks++; if (fwd_d_rs !== 2'b00) begin n_fail++; $display("[TB] FAIL z_fwd_d_rs: got %0b want 00", fwd_d_rs); end
        n_checks++; if (fwd_d_rt !== 2'b00) begin n_fail++; $display("[TB] FAIL z_fwd_d_rt: got %0b want 00", fwd_d_rt); end
        step();
        drive_nop();
        n_checks++; if (fwd_e_rs !== 2'b00) begin n_fail++; $display("[TB] FAIL z_fwd_e_rs: got %0b want 00", fwd_e_rs); end
        step();
        n_checks++; if (fwd_m_rt !== 1'b0)  begin n_fail++; $display("[TB] FAIL z_fwd_m_rt: got %0b want 0", fwd_m_rt); end
        flush();
    endtask

    task automatic test_store();
        // lw $1, 0($2) then sw $1, 0($2)
        drive_d(5'd2, 1'b1, 4'd1, 5'd0, 1'b0, TUSE_NONE, 5'd1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        step();
        drive_d(5'd2, 1'b1, 4'd1, 5'd1, 1'b1, 4'd2, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0)     begin n_fail++; $display("[TB] FAIL st_stall: got %0b want 0", stall); end
        step();
        drive_nop();
        n_checks++; if (fwd_e_rt !== 2'b00) begin n_fail++; $display("[TB] FAIL st_fwd_e_rt: got %0b want 00", fwd_e_rt); end
        step();
        n_checks++; if (fwd_m_rt !== 1'b1)  begin n_fail++; $display("[TB] FAIL st_fwd_m_rt: got %0b want 1", fwd_m_rt); end
        flush();
    endtask

    task automatic run_md(input logic is_div, input int exp_stall, input int exp_busy);
        int stall_cycles = 0;
        int busy_cycles  = 0;
        int guard        = 0;
        drive_d(5'd8, 1'b1, 4'd1, 5'd9, 1'b1, 4'd1, 5'd0, 1'b0, 4'd0, 1'b1, is_div, 1'b1);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL md_start_stall div=%0b: got %0b want 0", is_div, stall); end
        step();
        // mfhi $10
        drive_d(5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, TUSE_NONE, 5'd10, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        while (stall === 1'b1 && guard < 40) begin
            stall_cycles++;
            if (md_busy === 1'b1) busy_cycles++;
            step();
            guard++;
        end
        n_checks++; if (stall_cycles != exp_stall) begin n_fail++; $display("[TB] FAIL md_stall_len div=%0b: got %0d want %0d", is_div, stall_cycles, exp_stall); end
        n_checks++; if (busy_cycles != exp_busy)   begin n_fail++; $display("[TB] FAIL md_busy_len div=%0b: got %0d want %0d", is_div, busy_cycles, exp_busy); end
        n_checks++; if (md_busy !== 1'b0)          begin n_fail++; $display("[TB] FAIL md_busy_end div=%0b: got %0b want 0", is_div, md_busy); end
        flush();
    endtask

    task automatic test_md_stall();
        run_md(1'b1, 1 + DIV_LAT, DIV_LAT);
        run_md(1'b0, 1 + MULT_LAT, MULT_LAT);
    endtask

    task automatic test_md_restart();
        int n = 0;
        // div then mult issued back to back without HI/LO readers
        drive_d(5'd8, 1'b1, 4'd1, 5'd9, 1'b1, 4'd1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive_d(5'd8, 1'b1, 4'd1, 5'd9, 1'b1, 4'd1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        step();
        drive_nop();
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rs_busy_div: got %0b want 1", md_busy); end
        step();
        while (md_busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
        n_checks++; if (n != MULT_LAT) begin n_fail++; $display("[TB] FAIL rs_restart_len: got %0d want %0d", n, MULT_LAT); end
        flush();
    endtask

    task automatic test_reset_mid_div();
        drive_d(5'd8, 1'b1, 4'd1, 5'd9, 1'b1, 4'd1, 5'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        step();
        drive_nop();
        step();
        step(); step(); step();
        n_checks++; if (md_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_busy_before: got %0b want 1", md_busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_d(5'd0, 1'b0, TUSE_NONE, 5'd0, 1'b0, TUSE_NONE, 5'd10, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        n_checks++; if (md_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rd_busy_after: got %0b want 0", md_busy); end
        n_checks++; if (stall !== 1'b0)   begin n_fail++; $display("[TB] FAIL rd_stall_after: got %0b want 0", stall); end
        flush();
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        drive_nop();
        test_reset();
        test_load_use();
        test_branch();
        test_fwd_d_sources();
        test_back_to_back();
        test_zero_reg();
        test_store();
        test_md_stall();
        test_md_restart();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
